sort_engine: RTL
================

Name: sort_engine

Overview:
- Sequential sorter; parametrised successor to the single compare-swap element.
- Buffers up to DEPTH records and sorts them in place by an odd-even transposition network. Each record is a {symbol, frequency} word; the key is bits [OFFSET-1:0].
- Streams the sorted records out in ascending or descending key order.
- Sits between the frequency histogram and the Huffman tree/code-length builder.

Parameters:
- DSIZE, 18, record width in bits.
- OFFSET, 8, key width; key = record[OFFSET-1:0]. Must satisfy 1 <= OFFSET <= DSIZE.
- DEPTH, 16, maximum records per batch. Must be >= 2.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- descend  in  1  sort order, sampled on the first accepted record of a batch. 0 = ascending, 1 = descending.
- in_valid  in  1  input record valid.
- in_ready  out  1  engine can accept a record.
- in_data  in  DSIZE  input record.
- in_last  in  1  marks the final record of the batch.
- out_valid  out  1  sorted record valid.
- out_ready  in  1  downstream accepts the record.
- out_data  out  DSIZE  sorted record.
- out_last  out  1  final sorted record of the batch.
- busy  out  1  high in SORT and DRAIN.

Behaviour:
- FSM has three states: LOAD, SORT, DRAIN. Reset enters LOAD.
- Reset values: count=0, rd_ptr=0, pass=0, order=0, out_valid=0, out_last=0, out_data=0, busy=0, in_ready=1. Buffer contents are don't-care.
- in_ready = (state==LOAD). It is a combinational decode of the state register.
- LOAD:
  - On in_valid&&in_ready, write mem[count]=in_data and increment count.
  - If this is the first record of the batch, latch order=descend.
  - Move to SORT when the accepted record has in_last=1 or brings count to DEPTH.
  - A record arriving after count reaches DEPTH belongs to the next batch; it is not dropped, because in_ready is low.
- SORT takes exactly count cycles, with pass running 0..count-1:
  - Even pass: compare pairs (0,1),(2,3),…
  - Odd pass: compare pairs (1,2),(3,4),…
  - A pair (i,i+1) is active only if i+1 < count. Inactive slots are untouched.
  - Ascending swap condition: key[i] > key[i+1], strictly.
  - Descending swap condition: key[i] < key[i+1], strictly.
  - Equal keys never swap.
  - All pair updates in one pass happen in the same cycle.
  - When count=1, SORT lasts 1 cycle with no compares.
  - After the final pass, go to DRAIN with rd_ptr=0.
- DRAIN:
  - out_valid=1 and out_data=mem[rd_ptr], both registered so they are valid from the first DRAIN cycle.
  - out_last = (rd_ptr==count-1).
  - On out_valid&&out_ready, rd_ptr increments and the next record is presented in the following cycle.
  - out_data is held stable while out_ready=0.
  - On the handshake with out_last=1:
    - go to LOAD the next cycle;
    - clear count, rd_ptr and out_valid;
    - set in_ready=1.
- Latency: from the last input handshake, the first out_valid appears count+1 cycles later.
- Throughput: one record per cycle in both LOAD and DRAIN.
- Ordering guarantee:
  - Output is non-decreasing (ascending) or non-increasing (descending) by key.
  - Non-key bits [DSIZE-1:OFFSET] travel with their key.
  - Tie order between equal keys is implementation-defined.
- descend changes mid-batch have no effect; order is fixed per batch.
- Reset asserted in any state:
  - FSM returns to LOAD immediately (asynchronous); all outputs go to their reset values.
  - The partial batch is discarded.
- Ignored inputs:
  - in_valid outside LOAD is ignored.
  - out_ready outside DRAIN is ignored.

Test Plan:
- Ascending sort, 16 records, descend=0, keys 15..0 (upper bits = index) -> outputs keys 0..15 in order, each with its original upper bits. out_last is high only on the 16th record. First out_valid occurs 17 cycles after the last in handshake.
- Descending partial batch, descend=1, keys 3,9,1,9,5 with in_last on the 5th -> outputs keys 9,9,5,3,1, each carrying its original upper bits. SORT lasts 5 cycles. Exactly 5 records are emitted.
- Backpressure: drain the first test's batch with out_ready toggling 1,0,0,1 repeating -> no record lost or duplicated. out_data is stable during every stall. Return to LOAD only after the out_last handshake.
- Single record: in_data=18'h2A5C5 with in_last=1 -> SORT lasts 1 cycle; out_data=18'h2A5C5 with out_last=1.
- Full without in_last: 16 records with in_last=0 -> in_ready drops after the 16th. A 17th record presented with in_valid=1 is held off and is accepted as the first record of the next batch.
- Reset mid-SORT (count=8, pass=3): rst_n=0 -> in_ready=1, out_valid=0, busy=0 immediately. A new 2-record batch then sorts correctly.

Source files
------------

// File: rtl/sort_engine.sv
// rtl/sort_engine.sv - buffered odd-even transposition sorter.
// Loads a batch of records, sorts them in place by key, then streams them out.
module sort_engine #(
  parameter int DSIZE  = 18,
  parameter int OFFSET = 8,
  parameter int DEPTH  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             descend,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;

  state_t           state, state_nx;
  logic [DSIZE-1:0] mem    [DEPTH];
  logic [DSIZE-1:0] mem_nx [DEPTH];
  logic [CW-1:0]    count, rd_ptr, pass, rd_nx;
  logic             order;
  logic             accept, load_done, sort_done, out_hs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    in_ready  = (state == LOAD);
    busy      = (state != LOAD);
    accept    = in_valid && in_ready;
    load_done = accept && (in_last || count == CW'(DEPTH - 1));
    sort_done = (state == SORT) && (pass == count - 1'b1);
    out_hs    = (state == DRAIN) && out_valid && out_ready;
    rd_nx     = rd_ptr + 1'b1;
    state_nx  = state;
    case (state)
      LOAD:    if (load_done) state_nx = SORT;
      SORT:    if (sort_done) state_nx = DRAIN;
      DRAIN:   if (out_hs && out_last) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  // One transposition pass: pairs of the current parity whose upper slot is
  // still inside the batch are compared and swapped together.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_nx[i] = mem[i];
    for (int i = 0; i < DEPTH - 1; i++) begin
      if ((i % 2) == int'(pass[0]) && CW'(i + 1) < count) begin
        if (order ? (mem[i][OFFSET-1:0] < mem[i+1][OFFSET-1:0])
                  : (mem[i][OFFSET-1:0] > mem[i+1][OFFSET-1:0])) begin
          mem_nx[i]   = mem[i+1];
          mem_nx[i+1] = mem[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[count[AW-1:0]] <= in_data;
    end else if (state == SORT) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= mem_nx[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      rd_ptr    <= '0;
      pass      <= '0;
      order     <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            count <= count + 1'b1;
            if (count == '0) order <= descend;
          end
        end
        SORT: begin
          if (sort_done) begin
            // Take slot 0 from the final pass result so DRAIN starts valid.
            pass      <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b1;
            out_data  <= mem_nx[0];
            out_last  <= (count == CW'(1));
          end else begin
            pass <= pass + 1'b1;
          end
        end
        DRAIN: begin
          if (out_hs) begin
            if (out_last) begin
              count     <= '0;
              rd_ptr    <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              rd_ptr   <= rd_nx;
              out_data <= mem[rd_nx[AW-1:0]];
              out_last <= (rd_nx == count - 1'b1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
